// File: rtl/posit_defines.sv
// Shared widths and canonicalisation rule for denormalized posit lanes.
// Lane layout, MSB to LSB: sign, inf, zero, scale (two's complement), fraction (no hidden bit).
`ifndef GET_SCALE_WIDTH
`define GET_SCALE_WIDTH(n, es) ($clog2(n) + (es) + 1)
`endif
`ifndef GET_FRACTION_WIDTH
`define GET_FRACTION_WIDTH(n, es) ((n) - (es) - 3)
`endif

package posit_defines;

  typedef struct packed {
    logic sign;
    logic inf;
    logic zero;
    logic keep;  // scale/fraction survive canonicalisation
  } lane_flags_t;

  function automatic int unsigned lane_width(int unsigned sw, int unsigned fw);
    return 3 + sw + fw;
  endfunction

  // inf dominates zero; special values carry no sign and no payload.
  function automatic lane_flags_t canonicalise(logic sign, logic inf, logic zero);
    lane_flags_t f;
    if (inf) begin
      f = '{sign: 1'b0, inf: 1'b1, zero: 1'b0, keep: 1'b0};
    end else if (zero) begin
      f = '{sign: 1'b0, inf: 1'b0, zero: 1'b1, keep: 1'b0};
    end else begin
      f = '{sign: sign, inf: 1'b0, zero: 1'b0, keep: 1'b1};
    end
    return f;
  endfunction

endpackage

// File: rtl/posit_denorm_fifo_if.sv
// Valid/ready bus pair around the denormalized posit FIFO.
interface posit_denorm_fifo_if #(
  parameter int unsigned DATA_WIDTH = 48
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/posit_denorm_canon.sv
// Combinational single-lane canonicaliser: clears sign and payload of inf/zero lanes.
module posit_denorm_canon
  import posit_defines::*;
#(
  parameter int unsigned SW = 4,
  parameter int unsigned FW = 5
) (
  input  logic [SW+FW+2:0] lane_in,
  output logic [SW+FW+2:0] lane_out
);

  localparam int unsigned EW = lane_width(SW, FW);

  lane_flags_t flags;

  assign flags    = canonicalise(lane_in[EW-1], lane_in[EW-2], lane_in[EW-3]);
  assign lane_out = {flags.sign, flags.inf, flags.zero,
                     {(SW+FW){flags.keep}} & lane_in[SW+FW-1:0]};

endmodule

// File: rtl/posit_denorm_fifo.sv
// Multi-lane first-word fall-through FIFO for denormalized posits, canonicalising on write.
// Optional statistics outputs enabled by defining POSIT_DENORM_FIFO_STATS_EN.
module posit_denorm_fifo
  import posit_defines::*;
#(
  parameter int unsigned POSIT_WIDTH = 8,
  parameter int unsigned POSIT_ES    = 0,
  parameter int unsigned LANES       = 4,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  posit_denorm_fifo_if.slave       bus,
`ifdef POSIT_DENORM_FIFO_STATS_EN
  output logic [31:0]              stat_inf,
  output logic [31:0]              stat_zero,
  output logic [$clog2(DEPTH):0]   stat_max_count,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned SW = `GET_SCALE_WIDTH(POSIT_WIDTH, POSIT_ES);
  localparam int unsigned FW = `GET_FRACTION_WIDTH(POSIT_WIDTH, POSIT_ES);
  localparam int unsigned EW = lane_width(SW, FW);
  localparam int unsigned DW = LANES * EW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] canon_data;
  logic          push, pop;

  for (genvar g = 0; g < LANES; g++) begin : gen_canon
    posit_denorm_canon #(
      .SW(SW),
      .FW(FW)
    ) u_canon (
      .lane_in (bus.s_data[g*EW +: EW]),
      .lane_out(canon_data[g*EW +: EW])
    );
  end

  // s_ready looks only at occupancy, so a full FIFO never writes through.
  assign bus.s_ready = !rst && (count_q < CW'(DEPTH));
  assign bus.m_valid = (count_q != '0);
  assign bus.m_data  = bus.m_valid ? mem_q[rd_ptr_q] : '0;
  assign count       = count_q;

  assign push = bus.s_valid && bus.s_ready && !flush;
  assign pop  = bus.m_valid && bus.m_ready && !flush && !rst;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= canon_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

`ifdef POSIT_DENORM_FIFO_STATS_EN
  logic [LANES-1:0] head_inf, head_zero;
  logic [31:0]      stat_inf_q, stat_zero_q;
  logic [CW-1:0]    stat_max_q;
  logic [32:0]      inf_sum, zero_sum;

  for (genvar g = 0; g < LANES; g++) begin : gen_flags
    assign head_inf[g]  = bus.m_data[g*EW + EW - 2];
    assign head_zero[g] = bus.m_data[g*EW + EW - 3];
  end

  assign inf_sum  = {1'b0, stat_inf_q}  + 33'($countones(head_inf));
  assign zero_sum = {1'b0, stat_zero_q} + 33'($countones(head_zero));

  // Saturating counters; flush leaves history intact, only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_inf_q  <= '0;
      stat_zero_q <= '0;
      stat_max_q  <= '0;
    end else begin
      if (pop) begin
        stat_inf_q  <= inf_sum[32]  ? '1 : inf_sum[31:0];
        stat_zero_q <= zero_sum[32] ? '1 : zero_sum[31:0];
      end
      if (!flush && count_d > stat_max_q) begin
        stat_max_q <= count_d;
      end
    end
  end

  assign stat_inf       = stat_inf_q;
  assign stat_zero      = stat_zero_q;
  assign stat_max_count = stat_max_q;
`endif

endmodule

// File: tb/tb_posit_denorm_fifo.sv
// Directed self-checking bench for posit_denorm_fifo (N=8, ES=0, LANES=4, DEPTH=8).
module tb_posit_denorm_fifo;

  localparam int unsigned DW = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] count;
`ifdef POSIT_DENORM_FIFO_STATS_EN
  logic [31:0] stat_inf, stat_zero;
  logic [3:0]  stat_max_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  posit_denorm_fifo_if #(.DATA_WIDTH(DW)) bus ();

  posit_denorm_fifo #(
    .POSIT_WIDTH(8),
    .POSIT_ES   (0),
    .LANES      (4),
    .DEPTH      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .bus           (bus.slave),
`ifdef POSIT_DENORM_FIFO_STATS_EN
    .stat_inf      (stat_inf),
    .stat_zero     (stat_zero),
    .stat_max_count(stat_max_count),
`endif
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain lanes (flags clear): scale k, fraction k+lane.
  function automatic logic [47:0] word(input int k);
    logic [47:0] w;
    for (int g = 0; g < 4; g++) begin
      w[g*12 +: 12] = {3'b000, 4'(k), 5'(k + g)};
    end
    return w;
  endfunction

  // Plain lanes for streaming: 9-bit payload per lane.
  function automatic logic [47:0] sword(input int j);
    logic [47:0] w;
    for (int g = 0; g < 4; g++) begin
      w[g*12 +: 12] = {3'b000, 9'((j * 4 + g) % 512)};
    end
    return w;
  endfunction

  initial begin
    int sent, recvd, cyc;
    rst = 1'b1;
    flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.m_ready = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

    // Ordering: fill to full with m_ready low
    for (int i = 1; i <= 8; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = word(i);
      tick();
      if (i == 1) begin
        check("first_latency_valid", 64'(bus.m_valid), 64'd1);
        check("first_latency_data", 64'(bus.m_data), 64'(word(1)));
      end
    end
    bus.s_valid = 1'b0;
    check("full_count", 64'(count), 64'd8);
    check("full_s_ready", 64'(bus.s_ready), 64'd0);
    check("full_head_stable", 64'(bus.m_data), 64'(word(1)));

    // Full with s_valid and m_ready: pop only
    bus.s_valid = 1'b1;
    bus.s_data = word(9);
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    check("full_pushpop_count", 64'(count), 64'd7);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("order_%0d", i), 64'(bus.m_data), 64'(word(i)));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_m_valid", 64'(bus.m_valid), 64'd0);

    // Canonicalisation: lane0 inf, lane1 zero, lane2 inf+zero, lane3 plain negative
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = {12'h871, 12'hEE7, 12'hB43, 12'hCBF};
    tick();
    bus.s_valid = 1'b0;
    check("canon_lanes", 64'(bus.m_data), 64'({12'h871, 12'h400, 12'h200, 12'h400}));
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("canon_popped", 64'(count), 64'd0);

    // Simultaneous push+pop at count=3
    for (int i = 1; i <= 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = word(i);
      tick();
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.s_data = word(4 + i);
      check($sformatf("pp_head_%0d", i), 64'(bus.m_data), 64'(word(1 + i)));
      tick();
      check($sformatf("pp_count_%0d", i), 64'(count), 64'd3);
    end
    bus.s_valid = 1'b0;
    for (int i = 11; i <= 13; i++) begin
      check($sformatf("pp_drain_%0d", i), 64'(bus.m_data), 64'(word(i)));
      tick();
    end
    check("pp_empty", 64'(bus.m_valid), 64'd0);

    // Wrap-around stream with fixed backpressure pattern
    sent = 0;
    recvd = 0;
    cyc = 0;
    while ((recvd < 20) && (cyc < 300)) begin
      bus.s_valid = (sent < 20);
      bus.s_data = sword(sent);
      bus.m_ready = ((cyc % 3) != 0) && ((cyc % 7) != 5);
      #1;
      if (bus.m_valid && bus.m_ready) begin
        check($sformatf("stream_%0d", recvd), 64'(bus.m_data), 64'(sword(recvd)));
        recvd++;
      end
      if (bus.s_valid && bus.s_ready) sent++;
      tick();
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    check("stream_all_received", 64'(recvd), 64'd20);
    check("stream_empty", 64'(count), 64'd0);

    // Flush with count=5 and a concurrent push
    for (int i = 1; i <= 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = word(i);
      tick();
    end
    check("preflush_count", 64'(count), 64'd5);
    flush = 1'b1;
    bus.s_data = word(15);
    bus.m_ready = 1'b1;
    tick();
    flush = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_m_valid", 64'(bus.m_valid), 64'd0);
    check("flush_s_ready", 64'(bus.s_ready), 64'd1);
    bus.s_valid = 1'b1;
    bus.s_data = word(7);
    tick();
    bus.s_valid = 1'b0;
    check("postflush_count", 64'(count), 64'd1);
    check("postflush_head", 64'(bus.m_data), 64'(word(7)));

    // Reset mid-operation
    rst = 1'b1;
    #1;
    check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
    tick();
    rst = 1'b0;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
`ifdef POSIT_DENORM_FIFO_STATS_EN
    check("stat_rst_max", 64'(stat_max_count), 64'd0);
`endif

    // Special lanes for the stats path: 3 inf and 2 zero lanes across two words
    bus.s_valid = 1'b1;
    bus.s_data = {12'h400, 12'h400, 12'h200, 12'h021};
    tick();
    bus.s_data = {12'h400, 12'h200, 12'h042, 12'h063};
    tick();
    bus.s_valid = 1'b0;
    check("stat_word_b_queued", 64'(count), 64'd2);
    bus.m_ready = 1'b1;
    tick();
    tick();
    bus.m_ready = 1'b0;
    check("stat_drained", 64'(count), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef POSIT_DENORM_FIFO_STATS_EN
    check("stat_inf", 64'(stat_inf), 64'd3);
    check("stat_zero", 64'(stat_zero), 64'd2);
    check("stat_max_kept", 64'(stat_max_count), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stat_inf_rst", 64'(stat_inf), 64'd0);
    check("stat_zero_rst", 64'(stat_zero), 64'd0);
    check("stat_max_rst", 64'(stat_max_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
